// File: rtl/apb_wait_slave.sv
// APB3 completer with a four-word register file, programmable wait states and
// pslverr on misaligned, out-of-range or read-only accesses.
module apb_wait_slave #(
   parameter int WAIT_CYCLES = 0,
   parameter int ADDR_W      = 8
) (
   input  logic              pclk,
   input  logic              preset_n,
   input  logic              psel_i,
   input  logic              penable_i,
   input  logic              pwrite_i,
   input  logic [ADDR_W-1:0] paddr_i,
   input  logic [31:0]       pwdata_i,
   output logic              pready_o,
   output logic [31:0]       prdata_o,
   output logic              pslverr_o
);

   // state  | meaning
   // IDLE   | waiting for a setup phase (psel=1, penable=0)
   // WAIT   | access phase, counting down inserted wait states
   // READY  | pready_o high, transfer completes on the next access edge
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_READY} state_t;

   localparam logic [3:0] C_WAIT = WAIT_CYCLES[3:0];

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_write;
   logic        r_err;
   logic [1:0]  r_idx;
   logic [31:0] r_wdata;
   logic [31:0] r_reg0;
   logic [31:0] r_reg1;
   logic [31:0] r_reg2;
   logic [31:0] r_wcnt;

   logic        w_setup;
   logic        w_access;
   logic        w_err;
   logic [31:0] w_rdata_in;
   logic [31:0] w_rdata_lat;

   assign w_setup  = psel_i & ~penable_i;
   assign w_access = psel_i & penable_i;

   assign w_err = (paddr_i[1:0] != 2'b00)
                | (paddr_i[ADDR_W-1:4] != '0)
                | (pwrite_i & (paddr_i[3:2] == 2'd3));

   always_comb begin
      w_rdata_in = '0;
      case (paddr_i[3:2])
         2'd0:    w_rdata_in = r_reg0;
         2'd1:    w_rdata_in = r_reg1;
         2'd2:    w_rdata_in = r_reg2;
         default: w_rdata_in = r_wcnt;
      endcase
   end

   always_comb begin
      w_rdata_lat = '0;
      case (r_idx)
         2'd0:    w_rdata_lat = r_reg0;
         2'd1:    w_rdata_lat = r_reg1;
         2'd2:    w_rdata_lat = r_reg2;
         default: w_rdata_lat = r_wcnt;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (!preset_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_write   <= 1'b0;
         r_err     <= 1'b0;
         r_idx     <= '0;
         r_wdata   <= '0;
         r_reg0    <= '0;
         r_reg1    <= '0;
         r_reg2    <= '0;
         r_wcnt    <= '0;
         pready_o  <= 1'b0;
         prdata_o  <= '0;
         pslverr_o <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_setup) begin
                  r_write <= pwrite_i;
                  r_err   <= w_err;
                  r_idx   <= paddr_i[3:2];
                  r_wdata <= pwdata_i;
                  if (C_WAIT == 4'd0) begin
                     // zero-wait: the ready response is built straight from the bus
                     r_state   <= ST_READY;
                     pready_o  <= 1'b1;
                     pslverr_o <= w_err;
                     prdata_o  <= (!pwrite_i && !w_err) ? w_rdata_in : 32'd0;
                  end else begin
                     r_state <= ST_WAIT;
                     r_cnt   <= C_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (!psel_i) begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
               end else if (penable_i) begin
                  if (r_cnt == 4'd1) begin
                     r_state   <= ST_READY;
                     pready_o  <= 1'b1;
                     pslverr_o <= r_err;
                     prdata_o  <= (!r_write && !r_err) ? w_rdata_lat : 32'd0;
                  end
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_READY: begin
               if (!psel_i || w_access) begin
                  if (w_access && r_write && !r_err) begin
                     case (r_idx)
                        2'd0:    r_reg0 <= r_wdata;
                        2'd1:    r_reg1 <= r_wdata;
                        2'd2:    r_reg2 <= r_wdata;
                        default: ;
                     endcase
                     r_wcnt <= r_wcnt + 32'd1;
                  end
                  r_state   <= ST_IDLE;
                  r_cnt     <= '0;
                  pready_o  <= 1'b0;
                  pslverr_o <= 1'b0;
                  prdata_o  <= '0;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               pready_o  <= 1'b0;
               pslverr_o <= 1'b0;
               prdata_o  <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/apb_wait_slave.md
Name: apb_wait_slave

Overview:
- APB3 completer (responder) holding a small register file, sitting on the peripheral side of the APB bridge.
- Answers the transfers issued by the team's APB master.
- Inserts a programmable number of wait states and flags illegal accesses with pslverr.
- Gives the master-side bench a realistic, cycle-exact far end for write/read traffic.

Parameters:
- WAIT_CYCLES, 0, wait states inserted before pready_o rises in every transfer (0..15).
- ADDR_W, 8, width of paddr_i (byte address).

Ports:
- pclk  input  1  APB clock; all state updates on the rising edge.
- preset_n  input  1  synchronous active-low reset, sampled on the rising edge of pclk.
- psel_i  input  1  completer select.
- penable_i  input  1  access-phase indicator.
- pwrite_i  input  1  1 = write, 0 = read.
- paddr_i  input  ADDR_W  byte address.
- pwdata_i  input  32  write data.
- pready_o  output  1  transfer-complete strobe (registered).
- prdata_o  output  32  read data, valid while pready_o=1 on a read.
- pslverr_o  output  1  error response, valid only while pready_o=1.

Behaviour:
- Reset:
  - preset_n=0 at any edge forces state IDLE, clears wait counter, REG0..REG2 and WCNT to 0.
  - pready_o=0, prdata_o=0, pslverr_o=0.
  - A transfer in progress is dropped; no register is written.
- Register map, word index = paddr_i[3:2]:
  - 0x00 REG0 RW, 0x04 REG1 RW, 0x08 REG2 RW.
  - 0x0C WCNT RO, a 32-bit count of successful writes that wraps 0xFFFFFFFF -> 0.
- Error decode, latched at setup:
  - Error conditions: paddr_i[1:0]!=0; paddr_i >= 0x10; write to 0x0C.
  - Errored write changes no register and does not bump WCNT.
  - Errored read returns prdata_o=0.
- FSM states: IDLE, WAIT, READY.
- IDLE:
  - On psel_i=1 & penable_i=0 (setup sampled at edge T0), latch pwrite_i, paddr_i, pwdata_i and the error flag.
  - If WAIT_CYCLES=0: go to READY.
  - Else: go to WAIT with cnt=WAIT_CYCLES.
  - penable_i=1 without a prior setup is ignored.
- WAIT:
  - Each edge with psel_i=1 & penable_i=1 decrements cnt.
  - When cnt==1 at the edge, go to READY.
- Entry to READY (registered):
  - pready_o=1.
  - pslverr_o = latched error.
  - prdata_o = selected register on a legal read, else 0.
- READY:
  - At the next edge with psel_i=1 & penable_i=1 the transfer completes.
  - Legal write commits pwdata to the register and WCNT+1.
  - pready_o, pslverr_o and prdata_o return to 0; go to IDLE.
- Latency:
  - Setup edge to pready_o high = WAIT_CYCLES+1 edges.
  - Total transfer = WAIT_CYCLES+2 cycles.
  - Back-to-back transfers need a fresh setup cycle (IDLE sampled again); no pipelining.
- Abort: psel_i=0 sampled in WAIT or READY returns to IDLE with outputs cleared and no write.
- Read data is stable for the whole READY cycle even if the register changes later.
- Read of WCNT returns the count before the current transfer.

Test Plan:
- Reset, then idle 3 cycles -> pready_o=0, prdata_o=0, pslverr_o=0; reads of 0x00/0x04/0x08/0x0C all return 0x00000000.
- WAIT_CYCLES=0: write 0x1234abcd to 0x00, then read 0x00 -> pready_o high in the 2nd cycle of each transfer; read returns 0x1234abcd; pslverr_o=0; WCNT read = 1.
- WAIT_CYCLES=2: write 0x5678ef01 to 0x08 -> pready_o rises exactly 3 edges after setup; read 0x08 returns 0x5678ef01; read 0x04 returns 0.
- Errors:
  - Write 0xdeadbeef to 0x0C -> pslverr_o=1 with pready_o, and WCNT is unchanged.
  - Write to 0x02 -> pslverr_o=1 and REG0 is unchanged.
  - Read of 0x20 -> pslverr_o=1, prdata_o=0.
- Abort/reset:
  - WAIT_CYCLES=3: drop psel_i after 1 wait cycle of a write of 0xa5a5a5a5 to 0x04 -> REG1 stays 0, WCNT stays unchanged.
  - Repeat the write with preset_n=0 mid-wait -> all outputs 0 on the next edge and registers cleared.
- Back-to-back: 3 consecutive writes to 0x00 (0x1, 0x2, 0x3), each with a fresh setup cycle -> REG0=0x3 and WCNT=3.
